ram_share_arbiter: RTL and testbench

- Shares one single-port byte-addressed data RAM between two masters:
  - m0: CPU load/store unit.
  - m1: DMA/debug loader.
- Round-robin arbitration with a req/gnt handshake.
- Latches the winning command and drives the RAM for exactly one cycle, so the RAM's falling-edge write fires exactly once.
- Returns registered read data with a one-cycle rvalid pulse to the granted master.

---
 rtl/ram_share_arbiter_pkg.sv | 13 +
 rtl/ram_share_arbiter_rr_pick2.sv | 22 ++
 rtl/ram_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_share_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_share_arbiter_pkg.sv
// Shared types and constants for the two-master RAM arbiter (package ram_share_pkg).
package ram_share_pkg;
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;
endpackage

// File: rtl/ram_share_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the master that did not win last time wins.
module rr_pick2
    import ram_share_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);
    always_comb begin
        win_o = M0;
        if (req_i == 2'b11) begin
            win_o = ~last_i;
        end else if (req_i[1]) begin
            win_o = M1;
        end
        gnt_o = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o = win_o ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/ram_share_arbiter.sv
// Shares one single-port byte RAM between a CPU LSU (m0) and a DMA/debug loader (m1).
// Optional fault checking (range/alignment) is compiled in with RAM_SHARE_ARBITER_FAULT_EN.
module ram_share_arbiter
    import ram_share_pkg::*;
#(
    parameter int ADDR_WIDTH = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [2:0]  m0_size_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_rerr_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [2:0]  m1_size_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rerr_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_din_o,
    output logic        ram_we_o,
    output logic [2:0]  ram_size_o,
    input  logic [31:0] ram_dout_i
);
`ifdef RAM_SHARE_ARBITER_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    state_e      state_q;
    logic        last_q;
    logic        id_q;
    logic        we_q;
    logic        fault_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_din_q;
    logic        ram_we_q;
    logic [2:0]  ram_size_q;
    logic [1:0]  rvalid_q;
    logic [1:0]  rerr_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic [1:0]  pick_gnt;
    logic        pick_win;
    logic        idle;
    logic        we_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [2:0]  size_d;
    logic        fault_d;
    logic [31:0] load_d;

    rr_pick2 u_pick (
        .req_i  ({m1_req_i, m0_req_i}),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .win_o  (pick_win)
    );

    assign idle     = (state_q == ST_IDLE);
    assign m0_gnt_o = idle & pick_gnt[0];
    assign m1_gnt_o = idle & pick_gnt[1];

    always_comb begin
        we_d    = pick_win ? m1_we_i    : m0_we_i;
        addr_d  = pick_win ? m1_addr_i  : m0_addr_i;
        wdata_d = pick_win ? m1_wdata_i : m0_wdata_i;
        size_d  = pick_win ? m1_size_i  : m0_size_i;
        // Word alignment wins over half when both size bits are set.
        fault_d = FAULT_EN &&
                  (((addr_d >> ADDR_WIDTH) != 32'd0) ||
                   (size_d[1] && (addr_d[1:0] != 2'b00)) ||
                   (!size_d[1] && size_d[0] && addr_d[0]));
        load_d  = fault_q ? 32'd0 : ram_dout_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= M1;
            id_q       <= M0;
            we_q       <= 1'b0;
            fault_q    <= 1'b0;
            ram_addr_q <= 32'd0;
            ram_din_q  <= 32'd0;
            ram_we_q   <= 1'b0;
            ram_size_q <= 3'd0;
            rvalid_q   <= 2'b00;
            rerr_q     <= 2'b00;
            rdata0_q   <= 32'd0;
            rdata1_q   <= 32'd0;
        end else begin
            rvalid_q <= 2'b00;
            rerr_q   <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (pick_gnt != 2'b00) begin
                        id_q       <= pick_win;
                        last_q     <= pick_win;
                        we_q       <= we_d;
                        fault_q    <= fault_d;
                        ram_addr_q <= addr_d;
                        ram_din_q  <= wdata_d;
                        ram_size_q <= size_d;
                        ram_we_q   <= we_d & ~fault_d;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    ram_we_q       <= 1'b0;
                    rvalid_q[id_q] <= 1'b1;
                    rerr_q[id_q]   <= fault_q;
                    if (fault_q || !we_q) begin
                        if (id_q == M1) rdata1_q <= load_d;
                        else            rdata0_q <= load_d;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m0_rvalid_o = rvalid_q[0];
    assign m1_rvalid_o = rvalid_q[1];
    assign m0_rerr_o   = rerr_q[0];
    assign m1_rerr_o   = rerr_q[1];
    assign m0_rdata_o  = rdata0_q;
    assign m1_rdata_o  = rdata1_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_din_o   = ram_din_q;
    assign ram_we_o    = ram_we_q;
    assign ram_size_o  = ram_size_q;
endmodule

// File: tb/tb_ram_share_arbiter.sv
// Bench for ram_share_arbiter: byte RAM model, reference memory and directed/random steps.
module tb_ram_share_arbiter;
    import ram_share_pkg::*;

`ifdef RAM_SHARE_ARBITER_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic        id;
        logic        we;
        logic        fault;
        logic [31:0] addr;
        logic [31:0] res;
    } acc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        c_req   [2];
    logic        c_we    [2];
    logic [31:0] c_addr  [2];
    logic [31:0] c_wdata [2];
    logic [2:0]  c_size  [2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic        ram_we;
    logic [2:0]  ram_size;

    ram_share_arbiter #(.ADDR_WIDTH(7)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(c_req[0]), .m0_we_i(c_we[0]), .m0_addr_i(c_addr[0]),
        .m0_wdata_i(c_wdata[0]), .m0_size_i(c_size[0]),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_rerr_o(m0_rerr),
        .m1_req_i(c_req[1]), .m1_we_i(c_we[1]), .m1_addr_i(c_addr[1]),
        .m1_wdata_i(c_wdata[1]), .m1_size_i(c_size[1]),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_rerr_o(m1_rerr),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_we_o(ram_we),
        .ram_size_o(ram_size), .ram_dout_i(ram_dout)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- RAM model (falling-edge write, read data settled mid-cycle)
    logic [7:0] ram_mem [128];

    function automatic int size_bytes(logic [2:0] sz);
        return sz[1] ? 4 : (sz[0] ? 2 : 1);
    endfunction

    function automatic logic [31:0] ram_rd(logic [31:0] a, logic [2:0] sz);
        logic [31:0] v;
        logic [31:0] ba;
        int n;
        n = size_bytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if (ba < 32'd128) v[8*i +: 8] = ram_mem[ba[6:0]];
        end
        if (!sz[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    always @(negedge clk) begin
        logic [31:0] ba;
        if (ram_we) begin
            for (int i = 0; i < size_bytes(ram_size); i++) begin
                ba = ram_addr + 32'(i);
                if (ba < 32'd128) ram_mem[ba[6:0]] = ram_din[8*i +: 8];
            end
        end
        ram_dout <= ram_rd(ram_addr, ram_size);
    end

    // ---------------- reference model: memory image and access semantics
    logic [7:0]  ref_mem [128];
    logic [31:0] exp_rd  [2];
    logic        mdl_last;
    acc_t        s1, s2;

    function automatic logic [7:0] ref_byte(logic [31:0] a);
        return (a < 32'd128) ? ref_mem[a[6:0]] : 8'h00;
    endfunction

    function automatic logic exp_fault(logic [31:0] a, logic [2:0] sz);
        logic bad;
        bad = (a >= 32'd128) || (sz[1] ? (a % 4 != 0) : (sz[0] && (a % 2 != 0)));
        return FAULT_EN && bad;
    endfunction

    function automatic logic [31:0] ref_exec(logic we, logic [31:0] a, logic [31:0] wd,
                                             logic [2:0] sz, logic flt);
        logic [31:0] u;
        logic [31:0] ba;
        if (flt) return 32'd0;
        if (we) begin
            for (int i = 0; i < size_bytes(sz); i++) begin
                ba = a + 32'(i);
                if (ba < 32'd128) ref_mem[ba[6:0]] = wd[8*i +: 8];
            end
            return 32'd0;
        end
        u = {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
        case (sz)
            SZ_B:    return {{24{u[7]}}, u[7:0]};
            SZ_BU:   return {24'd0, u[7:0]};
            SZ_H:    return {{16{u[15]}}, u[15:0]};
            SZ_HU:   return {16'd0, u[15:0]};
            default: return u;
        endcase
    endfunction

    task automatic model_reset();
        s1.v = 1'b0; s2.v = 1'b0;
        mdl_last = M1;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    endtask

    // ---------------- checks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    // ---------------- per-cycle driver/monitor step
    logic gnt_any, gnt_m, obs_g0, obs_g1, seen_we, obs_rerr;
    int   n_rv1, n_we_cyc;

    task automatic tick();
        logic w, eg0, eg1;
        acc_t nx;
        @(negedge clk);
        eg0 = 1'b0; eg1 = 1'b0; w = M0;
        if (!s1.v && (c_req[0] || c_req[1])) begin
            w   = (c_req[0] && c_req[1]) ? ~mdl_last : c_req[1];
            eg0 = (w == M0);
            eg1 = (w == M1);
        end
        chk1("m0_gnt", m0_gnt, eg0);
        chk1("m1_gnt", m1_gnt, eg1);
        chk1("ram_we", ram_we, s1.v && s1.we && !s1.fault);
        if (s1.v) chk("ram_addr", ram_addr, s1.addr);
        chk1("m0_rvalid", m0_rvalid, s2.v && s2.id == M0);
        chk1("m1_rvalid", m1_rvalid, s2.v && s2.id == M1);
        if (s2.v) begin
            chk1("rerr", s2.id ? m1_rerr : m0_rerr, s2.fault);
            if (s2.fault || !s2.we) exp_rd[s2.id] = s2.res;
        end
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m1_rdata", m1_rdata, exp_rd[1]);
        obs_g0 = m0_gnt; obs_g1 = m1_gnt;
        if (ram_we) begin seen_we = 1'b1; n_we_cyc++; end
        if (m0_rvalid || m1_rvalid) obs_rerr = m0_rerr | m1_rerr;
        if (m1_rvalid) n_rv1++;
        gnt_any = eg0 | eg1;
        gnt_m   = w;
        s2 = s1;
        nx = '{v: 1'b0, id: 1'b0, we: 1'b0, fault: 1'b0, addr: 32'd0, res: 32'd0};
        if (gnt_any) begin
            nx.v     = 1'b1;
            nx.id    = w;
            nx.we    = c_we[w];
            nx.addr  = c_addr[w];
            nx.fault = exp_fault(c_addr[w], c_size[w]);
            nx.res   = ref_exec(c_we[w], c_addr[w], c_wdata[w], c_size[w], nx.fault);
            mdl_last = w;
        end
        s1 = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic m, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] sz);
        c_we[m] = we; c_addr[m] = a; c_wdata[m] = wd; c_size[m] = sz;
    endtask

    task automatic rand_cmd(input logic m);
        logic [2:0] tab [5];
        tab[0] = SZ_B; tab[1] = SZ_H; tab[2] = SZ_W; tab[3] = SZ_BU; tab[4] = SZ_HU;
        c_we[m]    = 1'($urandom_range(0, 1));
        c_size[m]  = tab[$urandom_range(0, 4)];
        c_addr[m]  = ($urandom_range(0, 9) == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 255)))
                                                 : 32'($urandom_range(0, 135));
        c_wdata[m] = $urandom;
    endtask

    task automatic do_access(input logic m, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] sz);
        set_cmd(m, we, a, wd, sz);
        c_req[m] = 1'b1;
        seen_we = 1'b0; obs_rerr = 1'b0; n_we_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (gnt_any && gnt_m == m) break;
        end
        c_req[m] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic prev;
        int   ng;
        for (int i = 0; i < 128; i++) begin ram_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        ram_dout = 32'd0;
        for (int m = 0; m < 2; m++) begin
            c_req[m] = 1'b0; c_we[m] = 1'b0; c_addr[m] = 32'd0; c_wdata[m] = 32'd0; c_size[m] = 3'd0;
        end
        model_reset();
        rst = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_m0_gnt", m0_gnt, 1'b0);
        chk1("rst_m1_gnt", m1_gnt, 1'b0);
        chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
        chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
        chk1("rst_m0_rerr", m0_rerr, 1'b0);
        chk1("rst_m1_rerr", m1_rerr, 1'b0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        chk("rst_ram_size", {29'd0, ram_size}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // m0 word store then load back
        do_access(M0, 1'b1, 32'h10, 32'hDEAD_BEEF, SZ_W);
        chk("store_we_cycles", 32'(n_we_cyc), 32'd1);
        do_access(M0, 1'b0, 32'h10, 32'd0, SZ_W);
        chk("load_word", m0_rdata, 32'hDEAD_BEEF);

        // both masters requesting continuously: grants must alternate
        rand_cmd(M0); rand_cmd(M1);
        c_req[0] = 1'b1; c_req[1] = 1'b1;
        ng = 0; prev = M0;
        for (int k = 0; k < 40 && ng < 8; k++) begin
            tick();
            if (obs_g0 || obs_g1) begin
                if (ng > 0) chk1("alternate", obs_g1, ~prev);
                prev = obs_g1;
                ng++;
                rand_cmd(obs_g1);
            end
        end
        chk("fair_grants", 32'(ng), 32'd8);
        c_req[0] = 1'b0; c_req[1] = 1'b0;
        tick(); tick();

        // m1 byte loads, signed and unsigned
        do_access(M0, 1'b1, 32'h10, 32'hDEAD_BEEF, SZ_W);
        do_access(M1, 1'b0, 32'h10, 32'd0, SZ_B);
        chk("m1_load_b", m1_rdata, 32'hFFFF_FFEF);
        do_access(M1, 1'b0, 32'h10, 32'd0, SZ_BU);
        chk("m1_load_bu", m1_rdata, 32'h0000_00EF);

        // reset while an m0 load is in its RAM cycle
        set_cmd(M0, 1'b0, 32'h10, 32'd0, SZ_W);
        c_req[0] = 1'b1;
        tick();
        c_req[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk1("rst_busy_we", ram_we, 1'b0);
        chk1("rst_busy_rvalid", m0_rvalid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (3) tick();
        rand_cmd(M0); rand_cmd(M1);
        c_req[0] = 1'b1; c_req[1] = 1'b1;
        tick();
        chk1("tie_after_rst", obs_g0, 1'b1);
        c_req[0] = 1'b0; c_req[1] = 1'b0;
        tick(); tick();

        // fault handling, or pass-through of out-of-range accesses
        if (FAULT_EN) begin
            do_access(M0, 1'b1, 32'h80, 32'h1234_5678, SZ_W);
            chk1("fault_no_we", seen_we, 1'b0);
            chk1("fault_st_rerr", obs_rerr, 1'b1);
            do_access(M1, 1'b0, 32'h02, 32'd0, SZ_W);
            chk1("fault_ld_rerr", obs_rerr, 1'b1);
            chk("fault_ld_rdata", m1_rdata, 32'd0);
        end else begin
            do_access(M1, 1'b0, 32'h80, 32'd0, SZ_W);
            chk1("oor_rerr", obs_rerr, 1'b0);
            chk("oor_rdata", m1_rdata, 32'd0);
        end

        // m1 request dropped while m0 is being served
        n_rv1 = 0;
        set_cmd(M0, 1'b0, 32'h20, 32'd0, SZ_W);
        c_req[0] = 1'b1;
        tick();
        c_req[0] = 1'b0;
        set_cmd(M1, 1'b0, 32'h24, 32'd0, SZ_W);
        c_req[1] = 1'b1;
        tick();
        c_req[1] = 1'b0;
        repeat (3) tick();
        chk("drop_m1_rvalid", 32'(n_rv1), 32'd0);

        // random traffic, including abandoned requests
        for (int k = 0; k < 300; k++) begin
            for (int m = 0; m < 2; m++) begin
                logic mi;
                mi = m[0];
                if (c_req[mi] && gnt_any && gnt_m == mi) begin
                    if ($urandom_range(0, 1) == 1) rand_cmd(mi);
                    else c_req[mi] = 1'b0;
                end else if (!c_req[mi]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        rand_cmd(mi);
                        c_req[mi] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    c_req[mi] = 1'b0;
                end
            end
            tick();
        end
        c_req[0] = 1'b0; c_req[1] = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
